// File: rtl/dev_bridge_ctrl.sv
// Device-space access sequencer: decodes MEM-stage loads/stores to one of two
// peripheral windows, runs a req/ack handshake with timeout, and stalls until done.
module dev_bridge_ctrl #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        err,
  output logic [1:0]  dev_req,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [1:0]  dev_ack,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1
);

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e      state_q, state_d;
  logic        tgt_q, tgt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic hit0, hit1, ack_tgt, timed_out;

  assign hit0      = (req_addr[31:4] == DEV0_BASE[31:4]);
  assign hit1      = (req_addr[31:4] == DEV1_BASE[31:4]);
  assign ack_tgt   = tgt_q ? dev_ack[1] : dev_ack[0];
  // The cycle being counted is the (cnt_q+1)-th ISSUE cycle.
  assign timed_out = ({1'b0, cnt_q} + 9'd1) >= TimeoutLim;

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    err_d        = 1'b0;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (hit0 || hit1) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            tgt_d   = !hit0;
            cnt_d   = 8'd0;
            state_d = StIssue;
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
            if (!req_we) begin
              dout_d       = 32'd0;
              dout_valid_d = 1'b1;
            end
          end
        end
      end
      StIssue: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (ack_tgt) begin
          state_d = StDone;
          if (!we_q) begin
            dout_d       = tgt_q ? dev_rdata1 : dev_rdata0;
            dout_valid_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (!we_q) begin
            dout_d       = 32'd0;
            dout_valid_d = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      tgt_q        <= 1'b0;
      cnt_q        <= 8'd0;
      dout_q       <= 32'd0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign stall      = ((state_q == StIdle) && req_valid) || (state_q == StIssue);
  assign dev_req    = (state_q == StIssue) ? (tgt_q ? 2'b10 : 2'b01) : 2'b00;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err        = err_q;
  assign dev_we     = we_q;
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;

endmodule

// File: tb/tb_dev_bridge_ctrl.sv
// Directed bench for dev_bridge_ctrl: hit/miss decode, ack latency, timeout,
// mid-transfer reset and back-to-back loads.
module tb_dev_bridge_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] dout;
  logic        dout_valid;
  logic        err;
  logic [1:0]  dev_req;
  logic        dev_we;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [1:0]  dev_ack;
  logic [31:0] dev_rdata0;
  logic [31:0] dev_rdata1;

  int total = 0;
  int bad   = 0;

  dev_bridge_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .dout       (dout),
    .dout_valid (dout_valid),
    .err        (err),
    .dev_req    (dev_req),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_ack    (dev_ack),
    .dev_rdata0 (dev_rdata0),
    .dev_rdata1 (dev_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards apply to the following edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    dev_ack    = 2'b00;
    dev_rdata0 = 32'd0;
    dev_rdata1 = 32'd0;
    cyc();
    cyc();
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_dvalid", 32'(dout_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(dev_req), 32'd0);
    chk("rst_we", 32'(dev_we), 32'd0);
    chk("rst_addr", dev_addr, 32'd0);
    chk("rst_wdata", dev_wdata, 32'd0);
    reset = 1'b1;

    // Load dev0, ack in first ISSUE cycle
    cyc();
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h0000_7F04;
    dev_rdata0 = 32'h1234_5678;
    #1;
    chk("t1_stall_idle", 32'(stall), 32'd1);
    chk("t1_req_idle", 32'(dev_req), 32'd0);
    cyc();
    dev_ack = 2'b01;
    #1;
    chk("t1_stall_iss", 32'(stall), 32'd1);
    chk("t1_req_iss", 32'(dev_req), 32'd1);
    chk("t1_addr", dev_addr, 32'h0000_7F04);
    chk("t1_we", 32'(dev_we), 32'd0);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("t1_stall_done", 32'(stall), 32'd0);
    chk("t1_dout", dout, 32'h1234_5678);
    chk("t1_dvalid", 32'(dout_valid), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_req_done", 32'(dev_req), 32'd0);
    req_valid = 1'b0;
    cyc();
    chk("t1_dvalid_off", 32'(dout_valid), 32'd0);
    chk("t1_dout_hold", dout, 32'h1234_5678);

    // Store dev1, ack on third ISSUE cycle
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_7F18;
    req_wdata = 32'hCAFE_0001;
    #1;
    chk("t2_stall_idle", 32'(stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) dev_ack = 2'b10;
      #1;
      chk("t2_req", 32'(dev_req), 32'd2);
      chk("t2_stall", 32'(stall), 32'd1);
    end
    chk("t2_we", 32'(dev_we), 32'd1);
    chk("t2_wdata", dev_wdata, 32'hCAFE_0001);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("t2_stall_done", 32'(stall), 32'd0);
    chk("t2_req_done", 32'(dev_req), 32'd0);
    chk("t2_dvalid", 32'(dout_valid), 32'd0);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_dout", dout, 32'h1234_5678);
    req_valid = 1'b0;
    cyc();

    // Load miss
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_7F20;
    #1;
    chk("t3_stall_idle", 32'(stall), 32'd1);
    chk("t3_req_idle", 32'(dev_req), 32'd0);
    cyc();
    chk("t3_stall_done", 32'(stall), 32'd0);
    chk("t3_req_done", 32'(dev_req), 32'd0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_dout", dout, 32'd0);
    chk("t3_dvalid", 32'(dout_valid), 32'd1);
    req_valid = 1'b0;
    cyc();
    chk("t3_err_off", 32'(err), 32'd0);

    // Back-to-back loads: dev0 then dev1
    req_valid  = 1'b1;
    req_addr   = 32'h0000_7F08;
    dev_rdata0 = 32'hA0A0_0001;
    dev_rdata1 = 32'hB0B0_0002;
    cyc();
    dev_ack = 2'b01;
    #1;
    chk("t6_req_a", 32'(dev_req), 32'd1);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("t6_dout_a", dout, 32'hA0A0_0001);
    chk("t6_dvalid_a", 32'(dout_valid), 32'd1);
    req_addr = 32'h0000_7F14;
    cyc();
    chk("t6_stall_b", 32'(stall), 32'd1);
    chk("t6_req_idle_b", 32'(dev_req), 32'd0);
    chk("t6_dvalid_gap", 32'(dout_valid), 32'd0);
    cyc();
    dev_ack = 2'b10;
    #1;
    chk("t6_req_b", 32'(dev_req), 32'd2);
    chk("t6_addr_b", dev_addr, 32'h0000_7F14);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("t6_dout_b", dout, 32'hB0B0_0002);
    chk("t6_dvalid_b", 32'(dout_valid), 32'd1);
    req_valid = 1'b0;
    cyc();

    // Reset during second ISSUE cycle, then a normal load
    req_valid = 1'b1;
    req_addr  = 32'h0000_7F0C;
    cyc();
    chk("t5_req_iss1", 32'(dev_req), 32'd1);
    cyc();
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("t5_req_iss2", 32'(dev_req), 32'd1);
    cyc();
    chk("t5_req_rst", 32'(dev_req), 32'd0);
    chk("t5_stall_rst", 32'(stall), 32'd0);
    chk("t5_dout_rst", dout, 32'd0);
    chk("t5_err_rst", 32'(err), 32'd0);
    chk("t5_dvalid_rst", 32'(dout_valid), 32'd0);
    reset = 1'b1;
    cyc();
    chk("t5_err_after", 32'(err), 32'd0);
    chk("t5_dvalid_after", 32'(dout_valid), 32'd0);
    req_valid  = 1'b1;
    req_addr   = 32'h0000_7F1C;
    dev_rdata1 = 32'h0C0C_0C0C;
    cyc();
    dev_ack = 2'b10;
    #1;
    chk("t5_req_new", 32'(dev_req), 32'd2);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("t5_dout_new", dout, 32'h0C0C_0C0C);
    chk("t5_dvalid_new", 32'(dout_valid), 32'd1);
    chk("t5_err_new", 32'(err), 32'd0);
    req_valid = 1'b0;
    cyc();

    // Load dev0 with no ack: 15-cycle timeout, stray dev1 ack ignored
    req_valid  = 1'b1;
    req_addr   = 32'h0000_7F00;
    dev_rdata0 = 32'hDEAD_BEEF;
    for (int i = 0; i < 15; i++) begin
      cyc();
      dev_ack = (i == 3) ? 2'b10 : 2'b00;
      #1;
      chk("t4_req", 32'(dev_req), 32'd1);
      chk("t4_stall", 32'(stall), 32'd1);
    end
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("t4_req_done", 32'(dev_req), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_dout", dout, 32'd0);
    chk("t4_dvalid", 32'(dout_valid), 32'd1);
    chk("t4_stall_done", 32'(stall), 32'd0);
    req_valid = 1'b0;
    cyc();
    chk("t4_err_off", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
